// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter sharing the memory T-port (write port plus
//               t_reg read address) between NUM_REQ requesters. Supports a
//               bounded bus lock for multi-word sequences. Read data is
//               returned one cycle after the grant through registered outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int LOCK_MAX = 16,
    localparam int c_ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ-1:0]      req_we,
    input  logic [NUM_REQ-1:0]      req_lock,
    input  logic [NUM_REQ*16-1:0]   req_addr,
    input  logic [NUM_REQ*16-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]      req_gnt,
    output logic                    rsp_valid,
    output logic [c_ID_W-1:0]       rsp_id,
    output logic [15:0]             rsp_data,
    output logic [15:0]             mem_t_reg,
    output logic [15:0]             mem_write_val,
    output logic                    mem_write,
    input  logic [15:0]             mem_t_val
);

    // lock_cnt must be able to hold the value LOCK_MAX
    localparam int          c_CNT_W   = (LOCK_MAX > 1) ? $clog2(LOCK_MAX + 1) : 1;
    localparam logic [c_ID_W-1:0] c_LAST_ID = c_ID_W'(NUM_REQ - 1);

    // Arbitration state
    logic [c_ID_W-1:0]  r_rr_ptr;
    logic               r_locked;
    logic [c_ID_W-1:0]  r_owner;
    logic [c_CNT_W-1:0] r_lock_cnt;

    // Registered read response
    logic               r_rsp_valid;
    logic [c_ID_W-1:0]  r_rsp_id;
    logic [15:0]        r_rsp_data;

    // Per-requester views of the packed address/data buses
    logic [15:0]        w_addr  [NUM_REQ];
    logic [15:0]        w_wdata [NUM_REQ];

    // Winner of the current cycle
    logic               w_sel_vld;
    logic [c_ID_W-1:0]  w_sel_id;
    logic               w_sel_we;
    logic [c_ID_W-1:0]  w_scan_id;
    logic               w_lock_expire;

    // Next index after v, wrapping at NUM_REQ-1 (works for non-power-of-2 counts)
    function automatic logic [c_ID_W-1:0] f_wrap_inc(input logic [c_ID_W-1:0] v);
        logic [c_ID_W-1:0] r;
        if (v == c_LAST_ID) begin
            r = '0;
        end else begin
            r = v + c_ID_W'(1);
        end
        return r;
    endfunction

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_addr[gi]  = req_addr[16*gi +: 16];
            assign w_wdata[gi] = req_wdata[16*gi +: 16];
        end
    endgenerate

    // Pick the winner: the lock owner only, or the first valid requester from rr_ptr
    always_comb begin
        w_sel_vld = 1'b0;
        w_sel_id  = '0;
        w_scan_id = r_rr_ptr;
        if (r_locked) begin
            w_sel_vld = req_valid[r_owner];
            w_sel_id  = r_owner;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!w_sel_vld && req_valid[w_scan_id]) begin
                    w_sel_vld = 1'b1;
                    w_sel_id  = w_scan_id;
                end
                w_scan_id = f_wrap_inc(w_scan_id);
            end
        end
        // Nothing reaches the memory while reset is held
        if (rst) begin
            w_sel_vld = 1'b0;
        end
    end

    // Steer the winner onto the T-port; an idle port is driven to zero
    always_comb begin
        req_gnt       = '0;
        mem_t_reg     = '0;
        mem_write_val = '0;
        mem_write     = 1'b0;
        w_sel_we      = 1'b0;
        if (w_sel_vld) begin
            req_gnt[w_sel_id] = 1'b1;
            mem_t_reg         = w_addr[w_sel_id];
            mem_write_val     = w_wdata[w_sel_id];
            w_sel_we          = req_we[w_sel_id];
            mem_write         = req_we[w_sel_id];
        end
    end

    // The lock runs out once this grant would reach LOCK_MAX consecutive cycles
    assign w_lock_expire = ((int'(r_lock_cnt) + 1) >= LOCK_MAX);

    // Round-robin pointer and lock bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_locked   <= 1'b0;
            r_owner    <= '0;
            r_lock_cnt <= '0;
        end else if (r_locked) begin
            // Owner idle, timed out or dropping lock: hand the port on
            if (!req_valid[r_owner] || w_lock_expire || !req_lock[r_owner]) begin
                r_locked   <= 1'b0;
                r_lock_cnt <= '0;
                r_rr_ptr   <= f_wrap_inc(r_owner);
            end else begin
                r_lock_cnt <= r_lock_cnt + c_CNT_W'(1);
            end
        end else if (w_sel_vld) begin
            // With LOCK_MAX=1 a lock would expire at once, so it is never taken
            if (req_lock[w_sel_id] && (LOCK_MAX > 1)) begin
                r_locked   <= 1'b1;
                r_owner    <= w_sel_id;
                r_lock_cnt <= c_CNT_W'(1);
            end else begin
                r_lock_cnt <= '0;
                r_rr_ptr   <= f_wrap_inc(w_sel_id);
            end
        end
    end

    // Capture read data at the grant edge; id/data hold while no read is returned
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= w_sel_vld && !w_sel_we;
            if (w_sel_vld && !w_sel_we) begin
                r_rsp_id   <= w_sel_id;
                r_rsp_data <= mem_t_val;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Scoreboard bench for mem_arbiter. Two instances share the
//               stimulus (LOCK_MAX=16 and LOCK_MAX=4); sel picks which one
//               the monitor checks. Each DUT has its own small memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    typedef struct {
        logic [1:0]  gnt;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wval;
        logic        chkw;
        logic        rv;
        logic        post_rst;
    } exp_t;

    typedef struct {
        logic        id;
        logic [15:0] data;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic [1:0]  vld = '0;
    logic [1:0]  we  = '0;
    logic [1:0]  lk  = '0;
    logic [15:0] a0 = '0, a1 = '0, d0 = '0, d1 = '0;

    logic [1:0]  gnt_a, gnt_b;
    logic        rv_a, rv_b, id_a, id_b, wr_a, wr_b;
    logic [15:0] data_a, data_b, treg_a, treg_b, wval_a, wval_b, tval_a, tval_b;

    logic [15:0] mem_a [0:255];
    logic [15:0] mem_b [0:255];

    exp_t exp_q[$];
    rsp_t rsp_q[$];
    int   passed = 0;
    int   total  = 0;
    bit   prev_read = 1'b0;
    bit   prev_rst  = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.NUM_REQ(2), .LOCK_MAX(16)) u_dut_a (
        .clk(clk), .rst(rst), .req_valid(vld), .req_we(we), .req_lock(lk),
        .req_addr({a1, a0}), .req_wdata({d1, d0}), .req_gnt(gnt_a),
        .rsp_valid(rv_a), .rsp_id(id_a), .rsp_data(data_a),
        .mem_t_reg(treg_a), .mem_write_val(wval_a), .mem_write(wr_a),
        .mem_t_val(tval_a)
    );

    mem_arbiter #(.NUM_REQ(2), .LOCK_MAX(4)) u_dut_b (
        .clk(clk), .rst(rst), .req_valid(vld), .req_we(we), .req_lock(lk),
        .req_addr({a1, a0}), .req_wdata({d1, d0}), .req_gnt(gnt_b),
        .rsp_valid(rv_b), .rsp_id(id_b), .rsp_data(data_b),
        .mem_t_reg(treg_b), .mem_write_val(wval_b), .mem_write(wr_b),
        .mem_t_val(tval_b)
    );

    // Memory models: preloaded during reset, combinational read, write at edge
    always @(posedge clk) begin
        if (rst) begin
            mem_a[8'h00] <= 16'h0000; mem_a[8'h10] <= 16'hBEEF;
            mem_a[8'h20] <= 16'hCAFE; mem_a[8'hFF] <= 16'h0000;
            mem_b[8'h00] <= 16'h0000; mem_b[8'h10] <= 16'hBEEF;
            mem_b[8'h20] <= 16'hCAFE; mem_b[8'hFF] <= 16'h0000;
        end else begin
            if (wr_a) mem_a[treg_a[7:0]] <= wval_a;
            if (wr_b) mem_b[treg_b[7:0]] <= wval_b;
        end
    end
    assign tval_a = mem_a[treg_a[7:0]];
    assign tval_b = mem_b[treg_b[7:0]];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: one expectation per cycle, read responses from a second queue
    exp_t m_e;
    rsp_t m_r;
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            m_e = exp_q.pop_front();
            chk("req_gnt",   sel ? gnt_b  : gnt_a,  m_e.gnt);
            chk("mem_write", sel ? wr_b   : wr_a,   m_e.wr);
            chk("mem_t_reg", sel ? treg_b : treg_a, m_e.addr);
            if (m_e.chkw) chk("mem_write_val", sel ? wval_b : wval_a, m_e.wval);
            chk("rsp_valid", sel ? rv_b : rv_a, m_e.rv);
            if (m_e.post_rst) begin
                chk("rst_rsp_id",   sel ? id_b   : id_a,   0);
                chk("rst_rsp_data", sel ? data_b : data_a, 0);
            end
            if (m_e.rv) begin
                if (rsp_q.size() == 0) begin
                    total++;
                    $display("FAIL rsp_queue: no expected response queued (t=%0t)", $time);
                end else begin
                    m_r = rsp_q.pop_front();
                    chk("rsp_id",   sel ? id_b   : id_a,   m_r.id);
                    chk("rsp_data", sel ? data_b : data_a, m_r.data);
                end
            end
        end
    end

    // One clock cycle of stimulus with its hand-computed grant and read data
    task automatic step(input logic [1:0] egnt, input logic [15:0] edata, input bit late_rst = 1'b0);
        exp_t e;
        rsp_t r;
        int   id;
        id         = egnt[1] ? 1 : 0;
        e.gnt      = egnt;
        e.rv       = prev_read;
        e.post_rst = prev_rst;
        if (rst) begin
            e.wr = 1'b0; e.addr = '0; e.wval = '0; e.chkw = 1'b1;
        end else if (egnt != 2'b00) begin
            e.wr   = we[id];
            e.addr = id ? a1 : a0;
            e.wval = id ? d1 : d0;
            e.chkw = 1'b1;
        end else begin
            e.wr = 1'b0; e.addr = '0; e.wval = '0; e.chkw = 1'b0;
        end
        exp_q.push_back(e);
        prev_read = !rst && !late_rst && (egnt != 2'b00) && !we[id];
        if (prev_read) begin
            r.id   = (id == 1);
            r.data = edata;
            rsp_q.push_back(r);
        end
        prev_rst = rst || late_rst;
        if (late_rst) begin
            @(negedge clk);
            #1 rst = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    // Two reset cycles; requests are raised in the second to check gating
    task automatic do_reset(input bit new_sel);
        rst = 1'b1; vld = '0; we = '0; lk = '0;
        step(2'b00, 16'h0);
        sel = new_sel;
        vld = 2'b11;
        step(2'b00, 16'h0);
        rst = 1'b0; vld = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        prev_rst = 1'b1;
        do_reset(1'b0);

        // Single read of preloaded word
        vld = 2'b01; we = '0; a0 = 16'h0010;
        step(2'b01, 16'hBEEF);
        vld = '0;
        step(2'b00, 16'h0);
        step(2'b00, 16'h0);

        // Round-robin between two continuous readers
        do_reset(1'b0);
        vld = 2'b11; a0 = 16'h0010; a1 = 16'h0020;
        for (int i = 0; i < 3; i++) begin
            step(2'b01, 16'hBEEF);
            step(2'b10, 16'hCAFE);
        end
        vld = '0;
        step(2'b00, 16'h0);

        // Write then read-after-write by requester 1
        do_reset(1'b0);
        vld = 2'b10; we = 2'b10; a1 = 16'h00FF; d1 = 16'h1234;
        step(2'b10, 16'h0);
        we = 2'b00;
        step(2'b10, 16'h1234);
        vld = '0;
        step(2'b00, 16'h0);

        // Lock held four cycles then released voluntarily (LOCK_MAX=16)
        do_reset(1'b0);
        vld = 2'b11; a0 = 16'h0010; a1 = 16'h0020; d1 = 16'h0; lk = 2'b01;
        repeat (4) step(2'b01, 16'hBEEF);
        lk = 2'b00;
        step(2'b01, 16'hBEEF);
        step(2'b10, 16'hCAFE);
        vld = '0;
        step(2'b00, 16'h0);

        // Lock timeout on the LOCK_MAX=4 instance
        do_reset(1'b1);
        vld = 2'b11; lk = 2'b01;
        repeat (4) step(2'b01, 16'hBEEF);
        step(2'b10, 16'hCAFE);
        step(2'b01, 16'hBEEF);
        vld = '0; lk = '0;
        step(2'b00, 16'h0);

        // Reset arriving on the edge that ends a granted read
        do_reset(1'b0);
        vld = 2'b01; a0 = 16'h0010;
        step(2'b01, 16'h0, 1'b1);
        step(2'b00, 16'h0);
        step(2'b00, 16'h0);
        rst = 1'b0; vld = 2'b11;
        step(2'b01, 16'hBEEF);
        vld = '0;
        step(2'b00, 16'h0);
        step(2'b00, 16'h0);

        chk("rsp_q_drained", rsp_q.size(), 0);
        chk("exp_q_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
